// File: rtl/fta_bus_pkg.sv
// FTA bus request/response types shared by all bus slaves.
// The LED port uses only a subset of the request fields.
package fta_bus_pkg;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    FIXED   = 3'b001,
    INCR    = 3'b010,
    ERC     = 3'b111
  } fta_cycle_type_t;

  typedef enum logic [1:0] {
    OKAY    = 2'b00,
    DECERR  = 2'b01,
    PROTERR = 2'b10,
    ERR     = 2'b11
  } fta_tranerr_t;

  typedef logic [7:0] fta_tid_t;

  typedef struct packed {
    fta_tid_t        tid;
    fta_cycle_type_t cti;
    logic            cyc;
    logic            we;
    logic [3:0]      sel;
    logic [31:0]     padr;
    logic [31:0]     dat;
  } fta_cmd_request32_t;

  typedef struct packed {
    fta_tid_t     tid;
    logic [3:0]   pri;
    logic         ack;
    logic         rty;
    fta_tranerr_t err;
    logic [31:0]  adr;
    logic [31:0]  dat;
  } fta_cmd_response32_t;

endpackage

// File: rtl/ledport_pkg.sv
// Register map indices (word index = padr[6:2]) and per-LED mode encoding.
package ledport_pkg;

  localparam logic [4:0] LEDP_DIR   = 5'd0;
  localparam logic [4:0] LEDP_MODE  = 5'd1;
  localparam logic [4:0] LEDP_PRESC = 5'd2;
  localparam logic [4:0] LEDP_BLINK = 5'd3;
  localparam logic [4:0] LEDP_DUTY0 = 5'd4;

  typedef enum logic [1:0] {
    LEDM_DIRECT   = 2'b00,
    LEDM_PWM      = 2'b01,
    LEDM_BLINK    = 2'b10,
    LEDM_PWMBLINK = 2'b11
  } ledp_mode_e;

endpackage

// File: rtl/ledport_timebase.sv
// Shared time base: prescaler tick, free-running PWM counter and blink phase
// that advances once per PWM wrap.
module ledport_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRE_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PRE_BITS-1:0] presc_i,
  input  logic [15:0]         blink_i,
  output logic [PWM_BITS-1:0] pwm_cnt_o,
  output logic                phase_o
);

  logic [PRE_BITS-1:0] pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [15:0]         blk_cnt_q, blk_cnt_d;
  logic                phase_q, phase_d;
  logic                tick, wrap;

  always_comb begin
    tick      = (pre_cnt_q == '0);
    wrap      = tick & (&pwm_cnt_q);
    pre_cnt_d = tick ? presc_i : pre_cnt_q - PRE_BITS'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    blk_cnt_d = blk_cnt_q;
    phase_d   = phase_q;
    // A zero half-period parks the blink output solidly on.
    if (blink_i == '0) begin
      blk_cnt_d = '0;
      phase_d   = 1'b1;
    end else if (wrap) begin
      if (({1'b0, blk_cnt_q} + 17'd1) == {1'b0, blink_i}) begin
        blk_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      blk_cnt_q <= '0;
      phase_q   <= 1'b1;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign pwm_cnt_o = pwm_cnt_q;
  assign phase_o   = phase_q;

endmodule

// File: rtl/ledport_pwm_fta32.sv
// FTA32 LED port: register file, registered single-cycle bus response and
// per-LED direct/PWM/blink output mux driven by a shared time base.
module ledport_pwm_fta32
  import fta_bus_pkg::*;
  import ledport_pkg::*;
#(
  parameter int NLED     = 8,
  parameter int PWM_BITS = 8,
  parameter int PRE_BITS = 16
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                cs,
  input  fta_cmd_request32_t  req,
  output fta_cmd_response32_t resp,
  output logic [NLED-1:0]     led
);

  logic [NLED-1:0]                dir_q, dir_d;
  logic [2*NLED-1:0]              mode_q, mode_d;
  logic [PRE_BITS-1:0]            presc_q, presc_d;
  logic [15:0]                    blink_q, blink_d;
  logic [NLED-1:0][PWM_BITS-1:0]  duty_q, duty_d;
  logic [NLED-1:0]                led_q, led_d;
  logic                           ack_q, ack_d;
  fta_tid_t                       tid_q;
  logic [31:0]                    adr_q, dat_q, rd_data;
  logic [4:0]                     idx;
  logic                           wr_en, pwm_on, phase;
  logic [PWM_BITS-1:0]            pwm_cnt;
  logic                           unused_req;

  assign unused_req = ^req;

  always_comb begin
    idx     = req.padr[6:2];
    wr_en   = cs & req.we;
    ack_d   = cs & (~req.we | (req.cti == ERC));
    dir_d   = dir_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    blink_d = blink_q;
    duty_d  = duty_q;
    rd_data = '0;
    // Read data comes from the pre-write registers, so a write never echoes itself.
    case (idx)
      LEDP_DIR:   rd_data[NLED-1:0]     = dir_q;
      LEDP_MODE:  rd_data[2*NLED-1:0]   = mode_q;
      LEDP_PRESC: rd_data[PRE_BITS-1:0] = presc_q;
      LEDP_BLINK: rd_data[15:0]         = blink_q;
      default: ;
    endcase
    for (int i = 0; i < NLED; i++) begin
      if (idx == LEDP_DUTY0 + 5'(i)) rd_data[PWM_BITS-1:0] = duty_q[i];
    end
    if (wr_en) begin
      case (idx)
        LEDP_DIR:   dir_d   = req.dat[NLED-1:0];
        LEDP_MODE:  mode_d  = req.dat[2*NLED-1:0];
        LEDP_PRESC: presc_d = req.dat[PRE_BITS-1:0];
        LEDP_BLINK: blink_d = req.dat[15:0];
        default: ;
      endcase
      for (int i = 0; i < NLED; i++) begin
        if (idx == LEDP_DUTY0 + 5'(i)) duty_d[i] = req.dat[PWM_BITS-1:0];
      end
    end
  end

  ledport_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRE_BITS (PRE_BITS)
  ) u_timebase (
    .clk       (clk),
    .rst       (rst),
    .presc_i   (presc_q),
    .blink_i   (blink_q),
    .pwm_cnt_o (pwm_cnt),
    .phase_o   (phase)
  );

  always_comb begin
    led_d  = '0;
    pwm_on = 1'b0;
    for (int i = 0; i < NLED; i++) begin
      pwm_on = (pwm_cnt < duty_q[i]);
      case (ledp_mode_e'(mode_q[2*i +: 2]))
        LEDM_DIRECT:   led_d[i] = dir_q[i];
        LEDM_PWM:      led_d[i] = dir_q[i] & pwm_on;
        LEDM_BLINK:    led_d[i] = dir_q[i] & phase;
        LEDM_PWMBLINK: led_d[i] = dir_q[i] & pwm_on & phase;
        default:       led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q   <= '0;
      mode_q  <= '0;
      presc_q <= '0;
      blink_q <= '0;
      duty_q  <= '0;
      led_q   <= '0;
      ack_q   <= 1'b0;
      tid_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      blink_q <= blink_d;
      duty_q  <= duty_d;
      led_q   <= led_d;
      ack_q   <= ack_d;
      if (cs) begin
        tid_q <= req.tid;
        adr_q <= req.padr;
        dat_q <= rd_data;
      end
    end
  end

  always_comb begin
    resp     = '0;
    resp.tid = tid_q;
    resp.pri = 4'd7;
    resp.ack = ack_q;
    resp.rty = 1'b0;
    resp.err = OKAY;
    resp.adr = adr_q;
    resp.dat = dat_q;
  end

  assign led = led_q;

endmodule

// File: tb/tb_ledport_pwm_fta32.sv
// Bench for ledport_pwm_fta32: directed steps plus random bus traffic, checked
// cycle by cycle against a behavioural model of registers, time base and LEDs.
module tb_ledport_pwm_fta32;
  import fta_bus_pkg::*;

  localparam int NLED     = 8;
  localparam int PWM_BITS = 8;
  localparam int PRE_BITS = 16;
  localparam logic [31:0] DIR_MASK  = (32'd1 << NLED) - 32'd1;
  localparam logic [31:0] MODE_MASK = (32'd1 << (2*NLED)) - 32'd1;
  localparam logic [31:0] PRE_MASK  = (32'd1 << PRE_BITS) - 32'd1;
  localparam logic [31:0] DUTY_MASK = (32'd1 << PWM_BITS) - 32'd1;
  localparam int PWM_TOP = (1 << PWM_BITS) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                cs;
  fta_cmd_request32_t  req;
  fta_cmd_response32_t resp;
  logic [NLED-1:0]     led;

  int n_err = 0;
  int n_chk = 0;

  // ---------------- clock / reset / DUT
  always #5 clk = ~clk;

  ledport_pwm_fta32 #(
    .NLED     (NLED),
    .PWM_BITS (PWM_BITS),
    .PRE_BITS (PRE_BITS)
  ) dut (
    .rst  (rst),
    .clk  (clk),
    .cs   (cs),
    .req  (req),
    .resp (resp),
    .led  (led)
  );

  // ---------------- reference model
  logic [31:0]     m_dir, m_mode, m_presc, m_blink;
  logic [31:0]     m_duty [NLED];
  int              m_pre, m_pwm, m_blk;
  logic            m_phase;
  logic [NLED-1:0] m_led;
  logic            exp_ack;
  logic [71:0]     exp_q[$];

  function automatic logic [31:0] m_read(int idx);
    if (idx == 0) return m_dir;
    if (idx == 1) return m_mode;
    if (idx == 2) return m_presc;
    if (idx == 3) return m_blink;
    if (idx >= 4 && idx < 4 + NLED) return m_duty[idx-4];
    return 32'd0;
  endfunction

  function automatic logic [NLED-1:0] m_led_fn();
    logic [NLED-1:0] r;
    r = '0;
    for (int i = 0; i < NLED; i++) begin
      bit on;
      int md;
      on = (m_pwm < int'(m_duty[i]));
      md = int'((m_mode >> (2*i)) & 32'd3);
      case (md)
        0: r[i] = m_dir[i];
        1: r[i] = m_dir[i] & on;
        2: r[i] = m_dir[i] & m_phase;
        default: r[i] = m_dir[i] & on & m_phase;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dir   <= 0;
      m_mode  <= 0;
      m_presc <= 0;
      m_blink <= 0;
      for (int i = 0; i < NLED; i++) m_duty[i] <= 0;
      m_pre   <= 0;
      m_pwm   <= 0;
      m_blk   <= 0;
      m_phase <= 1'b1;
      m_led   <= '0;
      exp_ack <= 1'b0;
      exp_q.delete();
    end else begin
      m_led   <= m_led_fn();
      exp_ack <= cs && (!req.we || req.cti == ERC);
      if (cs && (!req.we || req.cti == ERC))
        exp_q.push_back({req.tid, req.padr, m_read(int'(req.padr[6:2]))});
      if (cs && req.we) begin
        case (int'(req.padr[6:2]))
          0: m_dir   <= req.dat & DIR_MASK;
          1: m_mode  <= req.dat & MODE_MASK;
          2: m_presc <= req.dat & PRE_MASK;
          3: m_blink <= req.dat & 32'h0000_FFFF;
          default:
            if (int'(req.padr[6:2]) >= 4 && int'(req.padr[6:2]) < 4 + NLED)
              m_duty[int'(req.padr[6:2]) - 4] <= req.dat & DUTY_MASK;
        endcase
      end
      // One PWM step per prescaler expiry; blink advances on each full PWM period.
      if (m_pre == 0) begin
        m_pre <= int'(m_presc);
        m_pwm <= (m_pwm + 1) % (PWM_TOP + 1);
      end else begin
        m_pre <= m_pre - 1;
      end
      if (m_blink == 0) begin
        m_blk   <= 0;
        m_phase <= 1'b1;
      end else if (m_pre == 0 && m_pwm == PWM_TOP) begin
        if (m_blk + 1 == int'(m_blink)) begin
          m_blk   <= 0;
          m_phase <= ~m_phase;
        end else begin
          m_blk <= m_blk + 1;
        end
      end
    end
  end

  // ---------------- checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and compare every registered output.
  task automatic step();
    logic [71:0] e;
    @(negedge clk);
    if (!rst) begin
      chk("led", 32'(led), 32'(m_led));
      chk("ack", 32'(resp.ack), 32'(exp_ack));
      if (exp_ack && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tid", 32'(resp.tid), 32'(e[71:64]));
        chk("adr", resp.adr, e[63:32]);
        chk("dat", resp.dat, e[31:0]);
      end
    end
  endtask

  // ---------------- drivers
  task automatic op(input bit we, input bit erc, input logic [7:0] tid, input int idx,
                    input logic [31:0] dat);
    step();
    cs       = 1'b1;
    req      = '0;
    req.we   = we;
    req.cti  = erc ? ERC : CLASSIC;
    req.tid  = tid;
    req.padr = 32'(idx) << 2;
    req.dat  = dat;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      cs  = 1'b0;
      req = '0;
    end
  endtask

  task automatic count_led(input int bit_i, input int cycles, output int ones);
    ones = 0;
    repeat (cycles) begin
      step();
      ones += int'(led[bit_i]);
    end
  endtask

  // ---------------- directed + random sequence
  initial begin
    int ones;
    int guard;
    rst = 1'b1;
    cs  = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_ack", 32'(resp.ack), 32'd0);
    chk("reset_pri", 32'(resp.pri), 32'd7);

    for (int i = 0; i <= 4 + NLED; i++) op(1'b0, 1'b0, 8'(i), i, 32'd0);
    idle(2);

    op(1'b1, 1'b1, 8'h40, 0, 32'hFFFF_FFA5);
    op(1'b1, 1'b0, 8'h41, 1, 32'd0);
    idle(2);
    chk("dir_led", 32'(led), 32'hA5);
    op(1'b0, 1'b0, 8'h42, 0, 32'd0);
    idle(2);

    op(1'b1, 1'b1, 8'h50, 2, 32'd0);
    op(1'b1, 1'b1, 8'h51, 1, 32'd1);
    op(1'b1, 1'b1, 8'h52, 4, 32'd64);
    op(1'b1, 1'b1, 8'h53, 0, 32'd1);
    idle(3);
    count_led(0, 256, ones);
    chk("pwm_duty64", 32'(ones), 32'd64);
    op(1'b1, 1'b1, 8'h54, 4, 32'd0);
    idle(3);
    count_led(0, 256, ones);
    chk("pwm_duty0", 32'(ones), 32'd0);
    op(1'b1, 1'b1, 8'h55, 4, 32'd255);
    idle(3);
    count_led(0, 256, ones);
    chk("pwm_duty255", 32'(ones), 32'd255);

    op(1'b1, 1'b1, 8'h60, 2, 32'd3);
    op(1'b1, 1'b1, 8'h61, 3, 32'd2);
    op(1'b1, 1'b1, 8'h62, 1, 32'h8);
    op(1'b1, 1'b1, 8'h63, 0, 32'h2);
    idle(4100);
    count_led(1, 4096, ones);
    chk("blink_half", 32'(ones), 32'd2048);
    op(1'b1, 1'b1, 8'h64, 3, 32'd0);
    idle(3);
    count_led(1, 2048, ones);
    chk("blink_off_solid", 32'(ones), 32'd2048);

    op(1'b0, 1'b0, 8'h11, 0, 32'd0);
    op(1'b1, 1'b0, 8'h22, 0, 32'h3C);
    op(1'b0, 1'b0, 8'h33, 0, 32'd0);
    idle(3);

    op(1'b1, 1'b1, 8'h70, 2, 32'd0);
    idle(1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        idle($urandom_range(1, 4));
      end else begin
        int idx;
        logic [31:0] d;
        idx = $urandom_range(0, 15);
        d   = $urandom;
        if (idx == 2) d = 32'($urandom_range(0, 2));
        if (idx == 3) d = 32'($urandom_range(0, 3));
        op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), idx, d);
      end
    end
    idle(3);

    op(1'b1, 1'b1, 8'h80, 2, 32'd0);
    op(1'b1, 1'b1, 8'h81, 3, 32'd0);
    op(1'b1, 1'b1, 8'h82, 1, 32'd1);
    op(1'b1, 1'b1, 8'h83, 4, 32'd255);
    op(1'b1, 1'b1, 8'h84, 0, 32'd1);
    idle(3);
    guard = 0;
    while (led[0] !== 1'b1 && guard < 300) begin
      step();
      guard++;
    end
    chk("led0_before_rst", 32'(led[0]), 32'd1);
    op(1'b0, 1'b0, 8'h55, 0, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_ack", 32'(resp.ack), 32'd0);
    @(negedge clk);
    cs  = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i <= 4 + NLED; i++) op(1'b0, 1'b0, 8'(8'h90 + i), i, 32'd0);
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
